ksa_shuffle_engine: RTL and testbench
=====================================

# ksa_shuffle_engine

Parametrised RC4 key-scheduling engine. On a `start` pulse it optionally fills the 256-byte S memory with the identity permutation. It then performs the complete 256-iteration KSA swap loop (j = j + S[i] + key[i mod KEY_BYTES]; swap S[i], S[j]) and pulses `done`. It sits between the key-search controller and the single-port S RAM, and replaces the fixed 3-byte, externally-indexed shuffle FSM with a self-sequencing engine of configurable key length and RAM read latency.

## Interface
- KEY_BYTES, 3: secret key length in bytes, legal range 1..32.
- RD_LATENCY, 1: cycles from `mem_addr` valid to `mem_rdata` valid, legal range 1..3.

- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; honoured only in IDLE.
- init_en  in  1  sampled with `start`; 1 = run the FILL phase first.
- secret_key  in  KEY_BYTES*8  sampled with `start`; key[0] = bits [KEY_BYTES*8-1 -: 8] (big-endian).
- mem_rdata  in  8  S RAM read data.
- mem_addr  out  8  S RAM address.
- mem_wdata  out  8  S RAM write data.
- mem_we  out  1  S RAM write enable.
- busy  out  1  high from the cycle after an accepted `start` until `done` is high (inclusive).
- done  out  1  one-cycle completion pulse.

## Operation
- Registers: i (8b), j (8b), k (0..KEY_BYTES-1), s_i, s_j (8b), key_reg, init_reg, wait counter.
- All outputs are driven from registers and state only. There is no combinational path from inputs to outputs.
- **IDLE:** on `start`, capture `secret_key` and `init_en`, clear i/j/k, then go to FILL if `init_en`=1, else go to RD_SI. `start` in any other state is ignored.
- **FILL:** `mem_we`=1, `mem_addr`=i, `mem_wdata`=i, i++ each cycle. After i=255 is written, i wraps to 0 and the FSM goes to RD_SI.
- **RD_SI:** `mem_addr`=i for 1 cycle.
- **WAIT_SI:** lasts RD_LATENCY cycles with the address held. s_i <= `mem_rdata` on the last cycle.
- **CALC_J:** j <= j + s_i + key[k], mod 256 (8-bit wrap).
- **RD_SJ:** `mem_addr`=j for 1 cycle.
- **WAIT_SJ:** lasts RD_LATENCY cycles. s_j <= `mem_rdata` on the last cycle.
- **WR_SI:** `mem_we`=1, `mem_addr`=i, `mem_wdata`=s_j.
- **WR_SJ:** `mem_we`=1, `mem_addr`=j, `mem_wdata`=s_i.
- **NEXT:** if i=255, go to DONE. Otherwise i++, k = (k=KEY_BYTES-1) ? 0 : k+1, and go to RD_SI. No divider or modulo operator is used.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **i=j case:** both writes hit the same address; the WR_SJ value (s_i = s_j) is final, so the S entry is unchanged.
- **Reset in any state:** the FSM returns to IDLE on the next edge and all outputs go to 0. Memory contents are then undefined; the controller must restart with `init_en`=1.
- **Output reset values:** `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `busy`=0, `done`=0.
- `mem_addr` and `mem_wdata` read 0 in IDLE.

## Timing
- Cycle 0 is the `start` cycle (IDLE).
- The first FILL or RD_SI cycle is cycle 1.
- FILL takes 256 cycles.
- Each KSA iteration takes 6 + 2·RD_LATENCY cycles: RD_SI 1, WAIT_SI L, CALC_J 1, RD_SJ 1, WAIT_SJ L, WR_SI 1, WR_SJ 1, NEXT 1.
- `done` is high in cycle 1 + 256·init + 256·(6+2L):
  - L=1, init=1: cycle 2305.
  - L=1, init=0: cycle 2049.
- The earliest next `start` is honoured the cycle after `done`.
- Memory model: the RAM samples `mem_addr` on an edge. Read data is valid RD_LATENCY cycles after the address is first presented, and writes take effect on the edge ending a `mem_we` cycle.

## Test plan
- **Identity fill and zero key.** KEY_BYTES=3, L=1, `init_en`=1, key 24'h000000. Required: 256 FILL writes with addr=data=0..255; `done` in cycle 2305; final S equals the golden RC4 KSA model; `busy` high for cycles 1..2305.
- **First swap check.** Key 24'h4B6579 ("Key"). Required: the first WR_SI writes S[0]=8'h4B and the first WR_SJ writes S[8'h4B]=8'h00; final S matches the golden model.
- **Key wrap and latency scaling.** KEY_BYTES=5, L=2, key 40'h0102030405. Required: iteration 5 uses key byte 8'h01 (k wraps to 0); `done` in cycle 1+256+256·10 = 2817; final S matches the model.
- **No-init mode.** `init_en`=0 with the RAM preloaded to S[i]=255-i. Required: no FILL writes; the first `mem_addr`=0 read occurs in cycle 1; `done` in cycle 2049; final S matches the model run on the same preload.
- **Ignored start and mid-run reset.** Pulse `start` at cycle 500 of a run: ignored, timing unchanged. Assert `reset` at cycle 1000: next cycle all outputs are 0 and `busy`=0. A new `start` with `init_en`=1 must then complete correctly.
- **Self-swap.** KEY_BYTES=1, key 8'h00, `init_en`=1. Required: in iteration 0, j=0, both writes target addr 0 with data 0, and S[0] remains 0 after the iteration.

Source files
------------

// File: rtl/ksa_shuffle_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ksa_shuffle_engine : self-sequencing RC4 key schedule over a 1-port S RAM |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module ksa_shuffle_engine #(
  parameter int KEY_BYTES  = 3,
  parameter int RD_LATENCY = 1
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   init_en,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  input  logic [7:0]             mem_rdata,
  output logic [7:0]             mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   mem_we,
  output logic                   busy,
  output logic                   done
);

  localparam int            KW       = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] C_K_LAST = KW'(KEY_BYTES - 1);
  localparam logic [1:0]    C_W_LAST = 2'(RD_LATENCY - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FILL    = 4'd1,
    S_RD_SI   = 4'd2,
    S_WAIT_SI = 4'd3,
    S_CALC_J  = 4'd4,
    S_RD_SJ   = 4'd5,
    S_WAIT_SJ = 4'd6,
    S_WR_SI   = 4'd7,
    S_WR_SJ   = 4'd8,
    S_NEXT    = 4'd9,
    S_DONE    = 4'd10
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [7:0]             r_i;
  logic [7:0]             r_j;
  logic [7:0]             r_si;
  logic [7:0]             r_sj;
  logic [KW-1:0]          r_k;
  logic [1:0]             r_wcnt;
  logic [KEY_BYTES*8-1:0] r_key;
  logic [7:0]             w_key_byte;
  logic                   w_wait_last;

  assign w_wait_last = (r_wcnt == C_W_LAST);

  // key[0] sits in the most significant byte of the captured key
  always_comb begin
    w_key_byte = 8'h00;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (r_k == KW'(n)) w_key_byte = r_key[(KEY_BYTES-1-n)*8 +: 8];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    busy      = (r_state != S_IDLE);
    done      = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_next = init_en ? S_FILL : S_RD_SI;
      S_FILL: begin
        mem_we    = 1'b1;
        mem_addr  = r_i;
        mem_wdata = r_i;
        if (r_i == 8'hFF) w_next = S_RD_SI;
      end
      S_RD_SI: begin
        mem_addr = r_i;
        w_next   = S_WAIT_SI;
      end
      S_WAIT_SI: begin
        mem_addr = r_i;
        if (w_wait_last) w_next = S_CALC_J;
      end
      S_CALC_J:  w_next = S_RD_SJ;
      S_RD_SJ: begin
        mem_addr = r_j;
        w_next   = S_WAIT_SJ;
      end
      S_WAIT_SJ: begin
        mem_addr = r_j;
        if (w_wait_last) w_next = S_WR_SI;
      end
      S_WR_SI: begin
        mem_we    = 1'b1;
        mem_addr  = r_i;
        mem_wdata = r_sj;
        w_next    = S_WR_SJ;
      end
      // when i == j this second write lands last and restores the same value
      S_WR_SJ: begin
        mem_we    = 1'b1;
        mem_addr  = r_j;
        mem_wdata = r_si;
        w_next    = S_NEXT;
      end
      S_NEXT:    w_next = (r_i == 8'hFF) ? S_DONE : S_RD_SI;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_i    <= 8'h00;
      r_j    <= 8'h00;
      r_si   <= 8'h00;
      r_sj   <= 8'h00;
      r_k    <= '0;
      r_wcnt <= 2'd0;
      r_key  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_key  <= secret_key;
          r_i    <= 8'h00;
          r_j    <= 8'h00;
          r_k    <= '0;
          r_wcnt <= 2'd0;
        end
        S_FILL: r_i <= r_i + 8'd1;
        S_WAIT_SI: begin
          if (w_wait_last) begin
            r_si   <= mem_rdata;
            r_wcnt <= 2'd0;
          end else begin
            r_wcnt <= r_wcnt + 2'd1;
          end
        end
        S_CALC_J: r_j <= r_j + r_si + w_key_byte;
        S_WAIT_SJ: begin
          if (w_wait_last) begin
            r_sj   <= mem_rdata;
            r_wcnt <= 2'd0;
          end else begin
            r_wcnt <= r_wcnt + 2'd1;
          end
        end
        S_NEXT: if (r_i != 8'hFF) begin
          r_i <= r_i + 8'd1;
          r_k <= (r_k == C_K_LAST) ? '0 : r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ksa_shuffle_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ksa_shuffle_engine : directed vectors for the RC4 key-schedule engine  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_ksa_shuffle_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance 0: KEY_BYTES=3,L=1   instance 1: KEY_BYTES=5,L=2   instance 2: KEY_BYTES=1,L=1
  logic        rst[3];
  logic        start[3];
  logic        init_en[3];
  logic        preload[3];
  logic [23:0] key_a;
  logic [39:0] key_b;
  logic [7:0]  key_c;
  logic [7:0]  addr[3];
  logic [7:0]  wdata[3];
  logic [7:0]  rdata[3];
  logic [7:0]  p1[3];
  logic [7:0]  p2[3];
  logic        we[3];
  logic        busy[3];
  logic        done[3];
  logic [7:0]  mem[3][256];

  ksa_shuffle_engine #(.KEY_BYTES(3), .RD_LATENCY(1)) u_a (
    .CLOCK_50(clk), .reset(rst[0]), .start(start[0]), .init_en(init_en[0]),
    .secret_key(key_a), .mem_rdata(rdata[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_we(we[0]), .busy(busy[0]), .done(done[0]));
  ksa_shuffle_engine #(.KEY_BYTES(5), .RD_LATENCY(2)) u_b (
    .CLOCK_50(clk), .reset(rst[1]), .start(start[1]), .init_en(init_en[1]),
    .secret_key(key_b), .mem_rdata(rdata[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_we(we[1]), .busy(busy[1]), .done(done[1]));
  ksa_shuffle_engine #(.KEY_BYTES(1), .RD_LATENCY(1)) u_c (
    .CLOCK_50(clk), .reset(rst[2]), .start(start[2]), .init_en(init_en[2]),
    .secret_key(key_c), .mem_rdata(rdata[2]), .mem_addr(addr[2]),
    .mem_wdata(wdata[2]), .mem_we(we[2]), .busy(busy[2]), .done(done[2]));

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      p1[g] <= mem[g][addr[g]];
      p2[g] <= p1[g];
      if (preload[g]) begin
        for (int m = 0; m < 256; m++) mem[g][m] <= 8'(255 - m);
      end else if (we[g]) begin
        mem[g][addr[g]] <= wdata[g];
      end
    end
  end

  always_comb begin
    rdata[0] = p1[0];
    rdata[1] = p2[1];
    rdata[2] = p1[2];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int done_cyc;
  logic [7:0] tr_addr[3000];
  logic [7:0] tr_wd[3000];
  logic [7:0] tr_m0[3000];
  logic       tr_we[3000];
  logic       tr_busy[3000];
  logic       tr_done[3000];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Cycle 0 is the start cycle; outputs are sampled mid-cycle on the falling edge.
  task automatic run(input int g, input bit ini, input logic [39:0] key,
                     input int pulse_at, input int rst_at);
    done_cyc = -1;
    @(negedge clk);
    key_a = key[23:0];
    key_b = key;
    key_c = key[7:0];
    init_en[g] = ini;
    start[g]   = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) start[g] = 1'b0;
      if (pulse_at > 0 && c == pulse_at) begin
        start[g] = 1'b1; init_en[g] = ~ini; key_a = ~key_a;
      end
      if (pulse_at > 0 && c == pulse_at + 1) begin
        start[g] = 1'b0; init_en[g] = ini;
      end
      if (rst_at > 0 && c == rst_at)     rst[g] = 1'b1;
      if (rst_at > 0 && c == rst_at + 1) rst[g] = 1'b0;
      tr_addr[c] = addr[g];
      tr_wd[c]   = wdata[g];
      tr_we[c]   = we[g];
      tr_busy[c] = busy[g];
      tr_done[c] = done[g];
      tr_m0[c]   = mem[g][0];
      if (done[g] && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && c == done_cyc + 1) break;
      if (rst_at > 0 && c == rst_at + 1) break;
    end
  endtask

  // Reference KSA; ini=1 starts from identity, ini=0 from the reversed preload.
  task automatic check_final(input string name, input int g, input bit ini,
                             input int kb, input logic [39:0] key);
    logic [7:0] s[256];
    logic [7:0] t;
    logic [7:0] kbyte;
    int jj;
    int bad;
    for (int i = 0; i < 256; i++) s[i] = ini ? 8'(i) : 8'(255 - i);
    jj = 0;
    for (int i = 0; i < 256; i++) begin
      kbyte = key[(kb - 1 - (i % kb)) * 8 +: 8];
      jj    = (jj + int'(s[i]) + int'(kbyte)) % 256;
      t     = s[i];
      s[i]  = s[jj];
      s[jj] = t;
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[g][i] !== s[i]) bad++;
    chk(name, bad, 0);
  endtask

  typedef struct {
    int         g;
    bit         ini;
    logic [39:0] key;
    int         kb;
    int         exp_done;
    int         w1_cyc, w1_addr, w1_data;
    int         w2_cyc, w2_addr, w2_data;
    int         m0_cyc, m0_exp;
  } vec_t;

  vec_t vt[5];

  initial begin
    int g, nwe, fbad, bbad, c1, ex;
    vt[0] = '{0, 1'b1, 40'h0000000000, 3, 2305, 262, 8'h00, 8'h00, 263, 8'h00, 8'h00, 264, 8'h00};
    vt[1] = '{0, 1'b1, 40'h00004B6579, 3, 2305, 262, 8'h00, 8'h4B, 263, 8'h4B, 8'h00, 264, 8'h4B};
    vt[2] = '{1, 1'b1, 40'h0102030405, 5, 2817, 314, 8'h05, 8'h1B, 315, 8'h1B, 8'h05, 266, 8'h01};
    vt[3] = '{0, 1'b0, 40'h00004B6579, 3, 2049, 6,   8'h00, 8'hB5, 7,   8'h4A, 8'hFF, 8,   8'hB5};
    vt[4] = '{2, 1'b1, 40'h0000000000, 1, 2305, 262, 8'h00, 8'h00, 263, 8'h00, 8'h00, 264, 8'h00};

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; init_en[i] = 1'b0; preload[i] = 1'b0;
    end
    key_a = '0; key_b = '0; key_c = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_outputs_u%0d", i),
          int'({addr[i], wdata[i], we[i], busy[i], done[i]}), 0);

    for (int v = 0; v < 5; v++) begin
      g  = vt[v].g;
      ex = vt[v].exp_done;
      if (!vt[v].ini) begin
        @(negedge clk); preload[g] = 1'b1;
        @(negedge clk); preload[g] = 1'b0;
      end
      run(g, vt[v].ini, vt[v].key, -1, -1);
      chk($sformatf("v%0d_done_cycle", v), done_cyc, ex);
      nwe = 0; fbad = 0; bbad = 0;
      for (int c = 0; c <= ex + 1; c++) begin
        if (c <= ex && tr_we[c]) nwe++;
        if (vt[v].ini && c >= 1 && c <= 256 &&
            !(tr_we[c] && tr_addr[c] == 8'(c - 1) && tr_wd[c] == 8'(c - 1))) fbad++;
        if (tr_busy[c] != (c >= 1 && c <= ex)) bbad++;
        if (tr_done[c] != (c == ex)) bbad++;
      end
      chk($sformatf("v%0d_write_count", v), nwe, vt[v].ini ? 768 : 512);
      chk($sformatf("v%0d_fill_errors", v), fbad, 0);
      chk($sformatf("v%0d_busy_done_errors", v), bbad, 0);
      c1 = vt[v].ini ? 257 : 1;
      chk($sformatf("v%0d_first_read_we_addr", v), int'({tr_we[c1], tr_addr[c1]}), 0);
      chk($sformatf("v%0d_w1_we_addr_data", v),
          int'({tr_we[vt[v].w1_cyc], tr_addr[vt[v].w1_cyc], tr_wd[vt[v].w1_cyc]}),
          (1 << 16) | (vt[v].w1_addr << 8) | vt[v].w1_data);
      chk($sformatf("v%0d_w2_we_addr_data", v),
          int'({tr_we[vt[v].w2_cyc], tr_addr[vt[v].w2_cyc], tr_wd[vt[v].w2_cyc]}),
          (1 << 16) | (vt[v].w2_addr << 8) | vt[v].w2_data);
      chk($sformatf("v%0d_S0_after_iter", v), int'(tr_m0[vt[v].m0_cyc]), vt[v].m0_exp);
      check_final($sformatf("v%0d_final_S", v), g, vt[v].ini, vt[v].kb, vt[v].key);
    end

    // start pulsed mid-run must be ignored
    run(0, 1'b1, 40'h00004B6579, 500, -1);
    chk("ignored_start_busy", int'(tr_busy[502]), 1);
    chk("ignored_start_done_cycle", done_cyc, 2305);
    check_final("ignored_start_final_S", 0, 1'b1, 3, 40'h00004B6579);

    // reset in the middle of a run
    run(0, 1'b1, 40'h00004B6579, -1, 1000);
    chk("midreset_busy_before", int'(tr_busy[1000]), 1);
    chk("midreset_outputs_after",
        int'({tr_addr[1001], tr_wd[1001], tr_we[1001], tr_busy[1001], tr_done[1001]}), 0);
    chk("midreset_no_done", done_cyc, -1);
    run(0, 1'b1, 40'h00004B6579, -1, -1);
    chk("restart_done_cycle", done_cyc, 2305);
    check_final("restart_final_S", 0, 1'b1, 3, 40'h00004B6579);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
